// File: rtl/rv_mem_loader.sv
// rv_mem_loader
//   Host-side initiator for the CPU top's external data-memory load port.
//   It collects a little-endian byte stream into 32-bit words and writes
//   them to consecutive word addresses. The CPU is held in reset for the
//   whole load, because the CPU top only honours external writes while its
//   reset is high. The CPU is released once the load completes.
//
// Parameters
//   BOOT_HOLD  1: keep cpu_reset_o high from reset until the first load
//              completes. 0: release the CPU whenever the loader is idle.
//   CNT_W      width of the word counter and of num_words_i.
//
// Ports
//   clk_i, reset_i      clock (rising edge), async active-high reset
//   start_i             one-cycle pulse; latches base_addr_i / num_words_i
//   base_addr_i         byte address of the first word (bits [1:0] ignored)
//   num_words_i         number of words to load (0 is legal)
//   abort_i             abandon the load and return to idle
//   in_valid_i/in_data_i/in_ready_o   byte-stream handshake
//   cpu_reset_o         drives the CPU top reset
//   Ext_MemWrite_o / Ext_DataAdr_o / Ext_WriteData_o   memory load port
//   busy_o              high whenever the loader is not idle
//   done_o              one-cycle pulse when a load completes
module rv_mem_loader #(
  parameter int BOOT_HOLD = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             cpu_reset_o,
  output logic             Ext_MemWrite_o,
  output logic [31:0]      Ext_DataAdr_o,
  output logic [31:0]      Ext_WriteData_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] remaining_q;
  logic [1:0]       idx_q;
  logic [23:0]      word_q;       // lanes 0..2; lane 3 arrives with the last byte
  logic             in_ready_q;
  logic             mem_write_q;
  logic [31:0]      data_adr_q;
  logic [31:0]      write_data_q;
  logic             busy_q;
  logic             done_q;
  logic             cpu_reset_q;
  logic             accept;

  // abort has priority over a byte offered in the same cycle
  assign accept = in_valid_i && in_ready_q && !abort_i;

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (num_words_i == '0) ? S_FINISH : S_COLLECT;
      end
      S_COLLECT: begin
        if (abort_i)                        state_d = S_IDLE;
        else if (accept && idx_q == 2'd3)   state_d = S_WRITE;
      end
      S_WRITE: begin
        if (abort_i)                        state_d = S_IDLE;
        else if (remaining_q == CNT_W'(1))  state_d = S_FINISH;
        else                                state_d = S_COLLECT;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        first_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      first_q      <= 1'b0;
      addr_q       <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      in_ready_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      data_adr_q   <= '0;
      write_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      // outputs are decoded from the next state so they line up with it
      in_ready_q  <= (state_d == S_COLLECT);
      mem_write_q <= (state_d == S_WRITE);
      done_q      <= (state_d == S_FINISH);
      busy_q      <= (state_d != S_IDLE);
      cpu_reset_q <= (state_d != S_IDLE) || ((BOOT_HOLD != 0) && !first_d);

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q      <= base_addr_i & 32'hFFFF_FFFC;
            remaining_q <= num_words_i;
            idx_q       <= '0;
          end
        end
        S_COLLECT: begin
          if (abort_i) begin
            idx_q <= '0;
          end else if (accept) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
              2'd0: word_q[7:0]   <= in_data_i;
              2'd1: word_q[15:8]  <= in_data_i;
              2'd2: word_q[23:16] <= in_data_i;
              default: begin
                data_adr_q   <= addr_q;
                write_data_q <= {in_data_i, word_q};
              end
            endcase
          end
        end
        S_WRITE: begin
          addr_q      <= addr_q + 32'd4;
          remaining_q <= remaining_q - CNT_W'(1);
          idx_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign cpu_reset_o     = cpu_reset_q;
  assign Ext_MemWrite_o  = mem_write_q;
  assign Ext_DataAdr_o   = data_adr_q;
  assign Ext_WriteData_o = write_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_rv_mem_loader.sv
// Testbench for rv_mem_loader: directed loads with a write scoreboard and
// per-cycle output checks.
module tb_rv_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, cpu_reset, mem_write, busy, done;
  logic [31:0] data_adr, write_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [31:0] exp_adr_q[$];
  logic [31:0] exp_dat_q[$];
  logic [7:0]  tx_q[$];
  int          wr_cyc_q[$];
  logic [31:0] last_adr = '0;
  logic [31:0] last_dat = '0;

  rv_mem_loader #(.BOOT_HOLD(1), .CNT_W(16)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .base_addr_i     (base_addr),
    .num_words_i     (num_words),
    .abort_i         (abort),
    .in_valid_i      (in_valid),
    .in_data_i       (in_data),
    .in_ready_o      (in_ready),
    .cpu_reset_o     (cpu_reset),
    .Ext_MemWrite_o  (mem_write),
    .Ext_DataAdr_o   (data_adr),
    .Ext_WriteData_o (write_data),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every write must match the next expected word; between
  // writes the address/data outputs must hold the last written values.
  always @(negedge clk) begin
    if (reset) begin
      last_adr = '0;
      last_dat = '0;
    end else begin
      if (mem_write) begin
        wr_cyc_q.push_back(cyc);
        check("write_cpu_reset", 32'(cpu_reset), 1);
        check("write_in_ready", 32'(in_ready), 0);
        if (exp_adr_q.size() == 0) begin
          check("unexpected_write", 32'(mem_write), 0);
        end else begin
          last_adr = exp_adr_q.pop_front();
          last_dat = exp_dat_q.pop_front();
        end
      end
      check("data_adr", data_adr, last_adr);
      check("write_data", write_data, last_dat);
      if (busy) check("busy_cpu_reset", 32'(cpu_reset), 1);
      if (done) begin
        done_cnt++;
        check("finish_in_ready", 32'(in_ready), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // little-endian word: first byte on the stream is the least significant
  task automatic push_word(input logic [31:0] adr, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    exp_adr_q.push_back(adr);
    exp_dat_q.push_back(32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24));
    tx_q.push_back(b0);
    tx_q.push_back(b1);
    tx_q.push_back(b2);
    tx_q.push_back(b3);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    wr_cyc_q.delete();
    base_addr = b;
    num_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends up to max_bytes from tx_q; handshake decided mid-cycle.
  task automatic drive_stream(input bit stall, input int max_bytes);
    int sent = 0;
    int guard = 0;
    while (tx_q.size() > 0 && sent < max_bytes && guard < 500) begin
      in_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = tx_q[0];
      @(negedge clk);
      if (in_valid && in_ready) begin
        void'(tx_q.pop_front());
        sent++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("stream_timeout", 32'(guard < 500), 1);
  endtask

  task automatic wait_done(input string name, input logic exp_cpu_rst);
    int n = 0;
    exp_done++;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    check({name, "_done"}, 32'(done), 1);
    check({name, "_all_written"}, 32'(exp_adr_q.size()), 0);
    if (wr_cyc_q.size() > 0) check({name, "_done_latency"}, 32'(cyc - wr_cyc_q[$]), 1);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 0);
    check({name, "_busy_after"}, 32'(busy), 0);
    check({name, "_cpu_reset_after"}, 32'(cpu_reset), 32'(exp_cpu_rst));
    tick();
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data_adr", data_adr, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_cpu_reset", 32'(cpu_reset), 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_mem_write", 32'(mem_write), 0);
      check("idle_data_adr", data_adr, 0);
    end

    // two-word load, back-to-back bytes
    push_word(32'h100, 8'h78, 8'h56, 8'h34, 8'h12);
    push_word(32'h104, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    do_start(32'h100, 16'd2);
    check("t2_ready_latency", 32'(in_ready), 1);
    drive_stream(1'b0, 100);
    wait_done("t2", 1'b0);
    if (wr_cyc_q.size() == 2) check("t2_write_spacing", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 5);
    else check("t2_write_count", 32'(wr_cyc_q.size()), 2);
    check("t2_last_adr", data_adr, 32'h104);
    check("t2_last_data", write_data, 32'hDEADBEEF);

    // stalled stream, misaligned base
    push_word(32'h203 - (32'h203 % 4), 8'h11, 8'h22, 8'h33, 8'h44);
    do_start(32'h203, 16'd1);
    drive_stream(1'b1, 100);
    wait_done("t3", 1'b0);
    check("t3_adr", data_adr, 32'h200);
    check("t3_data", write_data, 32'h44332211);

    // zero-length load
    do_start(32'h300, 16'd0);
    check("t4_zero_done", 32'(done), 1);
    check("t4_zero_no_write", 32'(mem_write), 0);
    wait_done("t4z", 1'b0);

    // start pulsed during COLLECT is ignored
    push_word(32'h400, 8'h01, 8'h02, 8'h03, 8'h04);
    push_word(32'h404, 8'h05, 8'h06, 8'h07, 8'h08);
    do_start(32'h400, 16'd2);
    drive_stream(1'b0, 2);
    base_addr = 32'h800;
    num_words = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy_start", 32'(busy), 1);
    check("t4_ready_start", 32'(in_ready), 1);
    drive_stream(1'b0, 100);
    wait_done("t4b", 1'b0);
    check("t4_last_adr", data_adr, 32'h404);

    // abort after two bytes, then restart
    do_start(32'h500, 16'd1);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    drive_stream(1'b0, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_busy", 32'(busy), 0);
    check("t5_abort_ready", 32'(in_ready), 0);
    check("t5_abort_cpu_reset", 32'(cpu_reset), 0);
    repeat (3) tick();
    check("t5_abort_no_done", 32'(done_cnt), 32'(exp_done));
    push_word(32'h500, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    do_start(32'h500, 16'd1);
    drive_stream(1'b0, 100);
    wait_done("t5a", 1'b0);
    check("t5_restart_data", write_data, 32'hD4C3B2A1);

    // abort together with the fourth byte
    do_start(32'h600, 16'd1);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h03);
    drive_stream(1'b0, 3);
    in_valid = 1'b1;
    in_data  = 8'h99;
    abort    = 1'b1;
    @(negedge clk);
    check("t5b_ready_offered", 32'(in_ready), 1);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("t5b_busy", 32'(busy), 0);
    check("t5b_no_write", 32'(mem_write), 0);
    repeat (3) tick();
    check("t5b_no_done", 32'(done_cnt), 32'(exp_done));

    // asynchronous reset in the middle of WRITE
    do_start(32'h700, 16'd1);
    tx_q.push_back(8'h10);
    tx_q.push_back(8'h20);
    tx_q.push_back(8'h30);
    tx_q.push_back(8'h40);
    drive_stream(1'b0, 4);
    check("t6_in_write", 32'(mem_write), 1);
    #1 reset = 1'b1;
    #1;
    check("t6_async_mem_write", 32'(mem_write), 0);
    check("t6_async_cpu_reset", 32'(cpu_reset), 1);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_adr", data_adr, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t6_boot_hold_again", 32'(cpu_reset), 1);
    push_word(32'hFFFF_FFFC, 8'hC0, 8'hFF, 8'hEE, 8'h0B);
    do_start(32'hFFFF_FFFC, 16'd1);
    drive_stream(1'b0, 100);
    wait_done("t6", 1'b0);
    check("t6_top_adr", data_adr, 32'hFFFF_FFFC);

    // address wrap across the top of memory
    push_word(32'hFFFF_FFFC, 8'h01, 8'h23, 8'h45, 8'h67);
    push_word(32'hFFFF_FFFC + 32'd4, 8'h89, 8'hAB, 8'hCD, 8'hEF);
    do_start(32'hFFFF_FFFC, 16'd2);
    drive_stream(1'b0, 100);
    wait_done("t7", 1'b0);
    check("t7_wrap_adr", data_adr, 32'h0);
    check("t7_wrap_data", write_data, 32'hEFCDAB89);

    check("done_count", 32'(done_cnt), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
